// File: rtl/ins_decode_pkg.sv
// Shared opcode constants, format enum and decoded-field struct for the decode queue.
// Related build macro: INS_DECODE_ILLEGAL_CHK_EN (enables the per-entry illegal flag).
package ins_decode_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_UNK = 3'd7
    } fmt_t;

    // Width-independent part of a queue entry; imm/pc are appended at XLEN in the queue.
    typedef struct packed {
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [6:0] funct7;
        fmt_t       fmt;
    } dec_fields_t;

    function automatic logic r_funct7_ok(input logic [6:0] f7);
        return (f7 == 7'b0000000) || (f7 == 7'b0100000) || (f7 == 7'b0000001);
    endfunction

endpackage

// File: rtl/ins_decode_queue_imm_gen.sv
// Combinational format classification and sign-extended immediate generation.
// Used by ins_decode_queue (optional macro INS_DECODE_ILLEGAL_CHK_EN does not affect this block).
module imm_gen
    import ins_decode_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instruction,
    output logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);

    function automatic logic signed [XLEN-1:0] sext(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    fmt_t               fmt_c;
    logic signed [31:0] imm32;

    always_comb begin
        fmt_c = FMT_UNK;
        imm32 = '0;
        case (instruction[6:0])
            OP_R: begin
                fmt_c = FMT_R;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                fmt_c = FMT_I;
                imm32 = {{20{instruction[31]}}, instruction[31:20]};
            end
            OP_STORE: begin
                fmt_c = FMT_S;
                imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            end
            OP_BRANCH: begin
                fmt_c = FMT_B;
                imm32 = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                         instruction[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_c = FMT_U;
                imm32 = {instruction[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_c = FMT_J;
                imm32 = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                         instruction[30:21], 1'b0};
            end
            default: begin
                fmt_c = FMT_UNK;
            end
        endcase
    end

    assign fmt = fmt_c;
    assign imm = sext(imm32);

endmodule

// File: rtl/ins_decode_queue.sv
// Registered instruction decode stage: decode on entry, DEPTH-entry FIFO, flushable.
// Optional macro INS_DECODE_ILLEGAL_CHK_EN stores and reports a per-entry illegal flag.
module ins_decode_queue
    import ins_decode_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              instruction,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               opcode,
    output logic [4:0]               rd,
    output logic [2:0]               funct3,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [6:0]               funct7,
    output logic [2:0]               fmt,
    output logic [XLEN-1:0]          imm,
    output logic [XLEN-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     illegal
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        dec_fields_t     f;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
`ifdef INS_DECODE_ILLEGAL_CHK_EN
        logic            illegal;
`endif
    } entry_t;

    logic [2:0]      gen_fmt;
    logic [XLEN-1:0] gen_imm;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instruction (instruction),
        .fmt         (gen_fmt),
        .imm         (gen_imm)
    );

    // Stage p0: decoded entry ahead of storage
    entry_t dec_p0;

    always_comb begin
        dec_p0          = '0;
        dec_p0.f.opcode = instruction[6:0];
        dec_p0.f.rd     = instruction[11:7];
        dec_p0.f.funct3 = instruction[14:12];
        dec_p0.f.rs1    = instruction[19:15];
        dec_p0.f.rs2    = instruction[24:20];
        dec_p0.f.funct7 = instruction[31:25];
        dec_p0.f.fmt    = fmt_t'(gen_fmt);
        dec_p0.imm      = gen_imm;
        dec_p0.pc       = in_pc;
`ifdef INS_DECODE_ILLEGAL_CHK_EN
        dec_p0.illegal  = (dec_p0.f.fmt == FMT_UNK)
                       || ((instruction[6:0] == OP_R) && !r_funct7_ok(instruction[31:25]))
                       || (instruction[1:0] != 2'b11);
`endif
    end

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          vld_p0;
    logic          pop;

    // in_ready depends only on occupancy, so a pop never frees a slot in the same cycle
    assign in_ready  = (cnt != CW'(DEPTH));
    assign out_valid = (cnt != '0);
    assign vld_p0    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (vld_p0) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            case ({vld_p0, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Stage p1: storage array, deliberately left unreset
    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (vld_p0 && !flush) mem[wr_ptr] <= dec_p0;
    end

    entry_t head_p1;
    assign head_p1 = mem[rd_ptr];

    always_comb begin
        opcode  = '0;
        rd      = '0;
        funct3  = '0;
        rs1     = '0;
        rs2     = '0;
        funct7  = '0;
        fmt     = '0;
        imm     = '0;
        out_pc  = '0;
        illegal = 1'b0;
        if (out_valid) begin
            opcode  = head_p1.f.opcode;
            rd      = head_p1.f.rd;
            funct3  = head_p1.f.funct3;
            rs1     = head_p1.f.rs1;
            rs2     = head_p1.f.rs2;
            funct7  = head_p1.f.funct7;
            fmt     = head_p1.f.fmt;
            imm     = head_p1.imm;
            out_pc  = head_p1.pc;
`ifdef INS_DECODE_ILLEGAL_CHK_EN
            illegal = head_p1.illegal;
`endif
        end
    end

endmodule

// File: tb/tb_ins_decode_queue.sv
// Scoreboard bench for ins_decode_queue: driver pushes expectations, negedge monitor checks heads.
// Illegal-flag expectations follow INS_DECODE_ILLEGAL_CHK_EN.
module tb_ins_decode_queue;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

`ifdef INS_DECODE_ILLEGAL_CHK_EN
    localparam logic ILL_ON = 1'b1;
`else
    localparam logic ILL_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction;
    logic [XLEN-1:0]  in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [6:0]       funct7;
    logic [2:0]       fmt;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  out_pc;
    logic [2:0]       count;
    logic             illegal;

    ins_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .fmt         (fmt),
        .imm         (imm),
        .out_pc      (out_pc),
        .count       (count),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] vec_ins [8];
    exp_t        vec_exp [8];
    int          checks   = 0;
    int          failures = 0;

    // Hand-decoded reference vectors
    initial begin
        vec_ins[0] = 32'h00500093; // addi x1,x0,5
        vec_exp[0] = '{32'h0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd5, 7'h00, 3'd1, 32'h00000005, 1'b0};
        vec_ins[1] = 32'hFE000EE3; // beq x0,x0,-4
        vec_exp[1] = '{32'h0, 7'h63, 5'd29, 3'd0, 5'd0, 5'd0, 7'h7F, 3'd3, 32'hFFFFFFFC, 1'b0};
        vec_ins[2] = 32'h123452B7; // lui x5,0x12345
        vec_exp[2] = '{32'h0, 7'h37, 5'd5, 3'd5, 5'd8, 5'd3, 7'h09, 3'd4, 32'h12345000, 1'b0};
        vec_ins[3] = 32'h0020A423; // sw x2,8(x1)
        vec_exp[3] = '{32'h0, 7'h23, 5'd8, 3'd2, 5'd1, 5'd2, 7'h00, 3'd2, 32'h00000008, 1'b0};
        vec_ins[4] = 32'hFFFFFFFF; // unknown opcode
        vec_exp[4] = '{32'h0, 7'h7F, 5'd31, 3'd7, 5'd31, 5'd31, 7'h7F, 3'd7, 32'h00000000, ILL_ON};
        vec_ins[5] = 32'h002081B3; // add x3,x1,x2
        vec_exp[5] = '{32'h0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00, 3'd0, 32'h00000000, 1'b0};
        vec_ins[6] = 32'hFFFFF06F; // jal x0,-2
        vec_exp[6] = '{32'h0, 7'h6F, 5'd0, 3'd7, 5'd31, 5'd31, 7'h7F, 3'd5, 32'hFFFFFFFE, 1'b0};
        vec_ins[7] = 32'h202081B3; // R-type with funct7=0x10
        vec_exp[7] = '{32'h0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h10, 3'd0, 32'h00000000, ILL_ON};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every head that will be consumed at the next edge is checked against the scoreboard
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            exp_t act;
            exp_t req;
            act = '{out_pc, opcode, rd, funct3, rs1, rs2, funct7, fmt, imm, illegal};
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL head_unexpected actual=%0h required=none", act);
            end else begin
                req = sb.pop_front();
                if (act !== req) begin
                    failures++;
                    $display("FAIL head pc=%0h actual=%0h required=%0h", req.pc, act, req);
                end
            end
        end
    end

    task automatic drive(input bit v, input int idx, input logic [31:0] pc, input bit fl);
        bit   acc;
        exp_t e;
        in_valid    = v;
        instruction = vec_ins[idx];
        in_pc       = pc;
        flush       = fl;
        @(negedge clk);
        acc = v && (in_ready === 1'b1) && !fl;
        @(posedge clk);
        if (fl) sb.delete();
        if (acc) begin
            e    = vec_exp[idx];
            e.pc = pc;
            sb.push_back(e);
        end
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && count != 0; k++) drive(0, 0, 32'h0, 0);
        chk("drain_count", 64'(count), 64'd0);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        instruction = '0;
        in_pc       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_data", {25'd0, opcode, imm}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic decode, streaming push+pop with count held at 1
        out_ready = 1'b1;
        drive(1, 0, 32'h1000, 0);
        chk("first_count", 64'(count), 64'd1);
        drive(1, 1, 32'h1004, 0);
        chk("stream_count_b", 64'(count), 64'd1);
        drive(1, 2, 32'h1008, 0);
        chk("stream_count_c", 64'(count), 64'd1);
        drive(1, 3, 32'h100C, 0);
        drive(1, 4, 32'h1010, 0);
        drive(1, 5, 32'h1014, 0);
        drive(1, 6, 32'h1018, 0);
        drive(1, 7, 32'h101C, 0);
        drain();

        // Fill to DEPTH, fifth push refused, then drain in order
        out_ready = 1'b0;
        drive(1, 0, 32'h2000, 0);
        drive(1, 1, 32'h2004, 0);
        drive(1, 2, 32'h2008, 0);
        chk("fill_ready_before_full", 64'(in_ready), 64'd1);
        drive(1, 3, 32'h200C, 0);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd4);
        drive(1, 5, 32'h2010, 0);
        chk("full_count_after_5th", 64'(count), 64'd4);
        chk("full_sb_size", 64'(sb.size()), 64'd4);
        out_ready = 1'b1;
        drain();

        // Flush with three queued entries and a same-cycle push
        out_ready = 1'b0;
        drive(1, 2, 32'h3000, 0);
        drive(1, 3, 32'h3004, 0);
        drive(1, 5, 32'h3008, 0);
        chk("preflush_count", 64'(count), 64'd3);
        drive(1, 6, 32'h30F0, 1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_empty_data", {opcode, out_pc, 3'd0, rd}, 64'd0);
        out_ready = 1'b1;
        drive(1, 0, 32'h3100, 0);
        drain();

        // Asynchronous reset in the middle of a drain
        out_ready = 1'b0;
        drive(1, 1, 32'h4000, 0);
        drive(1, 2, 32'h4004, 0);
        drive(1, 3, 32'h4008, 0);
        out_ready = 1'b1;
        drive(0, 0, 32'h0, 0);
        chk("mid_drain_count", 64'(count), 64'd2);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_data", {opcode, out_pc, 5'd0, fmt}, 64'd0);
        sb.delete();
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        drive(1, 4, 32'h5000, 0);
        drain();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ins_decode_queue.md
Name: ins_decode_queue

Overview:
Registered RV32/RV64 instruction decode stage with valid/ready handshakes on both sides.
- Splits each accepted instruction into opcode, rd, funct3, rs1, rs2 and funct7.
- Classifies the instruction format and produces a sign-extended immediate.
- Buffers decoded entries in a DEPTH-entry FIFO.
- Sits between instruction fetch and register read; flushed on branch redirect.

Parameters:
XLEN, 32, immediate/PC width (32 or 64).
DEPTH, 4, FIFO entries (power of two, >=2).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous queue clear.
in_valid  input  1  instruction/PC valid.
in_ready  output  1  queue can accept.
instruction  input  32  raw instruction word.
in_pc  input  XLEN  instruction address.
out_valid  output  1  head entry valid.
out_ready  input  1  consumer accepts head.
opcode  output  7  head instr[6:0].
rd  output  5  head instr[11:7].
funct3  output  3  head instr[14:12].
rs1  output  5  head instr[19:15].
rs2  output  5  head instr[24:20].
funct7  output  7  head instr[31:25].
fmt  output  3  format: R=0, I=1, S=2, B=3, U=4, J=5, UNK=7.
imm  output  XLEN  sign-extended immediate.
out_pc  output  XLEN  head PC.
count  output  $clog2(DEPTH)+1  occupancy.
illegal  output  1  head opcode unsupported (feature only; otherwise tied 0).

Behaviour:
- Reset (reset_n low, async): count=0, pointers=0, out_valid=0, every data output=0. Storage array is not reset.
- Push: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- in_ready = (count < DEPTH). No combinational path from out_ready to in_ready. When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0). Outputs show the head entry. All data outputs read 0 when the queue is empty.
- Latency: an instruction pushed at edge N is visible on the outputs after edge N; minimum 1 cycle.
- Decode is combinational on `instruction` before storage; the stored entry is {fields, fmt, imm, pc}.
- Format and immediate by opcode:
  - 0110011 -> R, imm=0.
  - 0010011, 0000011, 1100111 -> I, imm = sext(i[31:20]).
  - 0100011 -> S, imm = sext({i[31:25], i[11:7]}).
  - 1100011 -> B, imm = sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - 0110111, 0010111 -> U, imm = sext({i[31:12], 12'b0}).
  - 1101111 -> J, imm = sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - Any other opcode -> UNK, imm=0.
- Sign extension: replicate i[31] up to XLEN. For XLEN=64, U-type bits 63:32 equal i[31].
- Pointers wrap modulo DEPTH. Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
- Empty with push: entry visible the next cycle. A pop while empty is ignored.
- flush (priority over push and pop): count=0 and pointers=0 at that edge. A same-cycle push is dropped. out_valid=0 the next cycle.
- Reset asserted mid-stream discards all entries immediately.

Optional Feature:
INS_DECODE_ILLEGAL_CHK_EN
- Defined:
  - illegal is stored per entry.
  - illegal=1 when fmt=UNK.
  - illegal=1 when an R-type has funct7 not in {0000000, 0100000, 0000001}.
  - illegal=1 when instruction[1:0] != 2'b11.
  - Flagged entries are still queued.
- Undefined: illegal is tied 0 and no storage bit is allocated.

Decomposition:
- Package ins_decode_pkg holds:
  - Opcode localparams: OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
  - The fmt_t enum (3 bits).
  - The decoded-entry struct typedef parametrised by XLEN via a width constant.
- Sub-module imm_gen: combinational opcode/instruction -> {fmt, imm}. The queue module instantiates it.

Test Plan:
- 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle opcode=0x13, rd=1, rs1=0, fmt=I, imm=5.
- 0xFE000EE3 (beq x0,x0,-4) -> fmt=B, imm=0xFFFFFFFC. With XLEN=64 -> imm=0xFFFFFFFFFFFFFFFC.
- 0x123452B7 (lui x5,0x12345) -> fmt=U, rd=5, imm=0x12345000. Then 0x0020A423 (sw x2,8(x1)) -> fmt=S, rs1=1, rs2=2, imm=8.
- Fill: out_ready=0, push 5 instructions with DEPTH=4 -> in_ready=0 after the 4th, 5th not accepted, count=4. Then out_ready=1 -> entries drain in push order, out_pc matches.
- flush with count=3 and same-cycle in_valid=1 -> next cycle count=0, out_valid=0, and the flushed-cycle instruction never appears.
- 0xFFFFFFFF with the macro defined -> fmt=UNK, illegal=1. Macro undefined -> illegal=0. reset_n pulled low mid-drain -> out_valid=0 immediately, without waiting for a clock edge.
